// File: rtl/bus_if_pkg.sv
// Purpose: shared constants and helpers for the bus driver FIFO endpoint.
//   DEST_W        - width of the destination ID field at the top of a packet
//   BROADCAST_ID  - destination ID accepted by every driver
//   ERR_*         - bit positions inside err_flags
//   dest_of()     - extracts the destination ID from a packet of width w
package bus_if_pkg;

  localparam int unsigned DEST_W       = 8;
  localparam logic [DEST_W-1:0] BROADCAST_ID = 8'hFF;
  localparam int unsigned PKT_MAX_W    = 256;

  localparam int unsigned ERR_TX_OVERFLOW  = 0;
  localparam int unsigned ERR_TX_UNDERFLOW = 1;
  localparam int unsigned ERR_RX_OVERFLOW  = 2;
  localparam int unsigned ERR_RX_MISROUTE  = 3;
  localparam int unsigned ERR_W            = 4;

  // Packet is passed zero-extended to PKT_MAX_W; w is the real packet width.
  function automatic logic [DEST_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned w);
    return DEST_W'(pkt >> (w - DEST_W));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Purpose: synchronous first-word-fall-through FIFO with occupancy counter.
// Ports:
//   clk_i, reset_i     - clock, synchronous active-high reset
//   wr_en_i, wr_data_i - write request and data
//   rd_en_i            - consume head this cycle
//   rd_data_o          - head entry (show-ahead), 0 when empty
//   full_o, empty_o    - registered status
//   count_o            - occupancy
//   overflow_c         - write refused this cycle (full, no read)
//   underflow_c        - read requested while empty
module sync_fifo_fwft #(
  parameter int unsigned bits  = 32,
  parameter int unsigned depth = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [bits-1:0]        wr_data_i,
  input  logic                   rd_en_i,
  output logic [bits-1:0]        rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(depth):0] count_o,
  output logic                   overflow_c,
  output logic                   underflow_c
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [bits-1:0] mem_q [depth];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            wr_ok, rd_ok;

  // Accept/consume decisions and next-state pointers/occupancy.
  always_comb begin
    rd_ok    = rd_en_i && !empty_q;
    // Full FIFO still takes a write when the head leaves in the same cycle.
    wr_ok    = wr_en_i && (!full_q || rd_en_i);
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CW'(1);
    end
    full_d      = (count_d == CW'(depth));
    empty_d     = (count_d == '0);
    overflow_c  = wr_en_i && full_q && !rd_en_i;
    underflow_c = rd_en_i && empty_q;
  end

  // Control state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; stale contents are masked by empty_q.
  always_ff @(posedge clk_i) begin
    if (wr_ok && !reset_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/bus_drvr_fifo_if.sv
// Purpose: driver-side bus endpoint: TX FIFO toward the arbiter, RX FIFO
//   with destination-ID filter toward the local agent, sticky error flags.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   tx_push, tx_data, tx_full       - local agent TX write side
//   pndng, pop, D_pop               - arbiter read side of TX FIFO
//   push, D_push                    - bus delivery into RX path
//   rx_pndng, rx_pop, rx_data       - local agent RX read side
//   tx_count, rx_count              - occupancies
//   err_flags                       - {rx_misroute, rx_overflow, tx_underflow, tx_overflow}
module bus_drvr_fifo_if
  import bus_if_pkg::*;
#(
  parameter int unsigned       bits      = 32,
  parameter int unsigned       depth     = 8,
  parameter logic [DEST_W-1:0] id        = 8'h00,
  parameter logic [DEST_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_push,
  input  logic [bits-1:0]        tx_data,
  output logic                   tx_full,
  output logic                   pndng,
  input  logic                   pop,
  output logic [bits-1:0]        D_pop,
  input  logic                   push,
  input  logic [bits-1:0]        D_push,
  output logic                   rx_pndng,
  input  logic                   rx_pop,
  output logic [bits-1:0]        rx_data,
  output logic [$clog2(depth):0] tx_count,
  output logic [$clog2(depth):0] rx_count,
  output logic [ERR_W-1:0]       err_flags
);

  logic              tx_empty, rx_empty, rx_full_unused;
  logic              tx_ovf, tx_udf, rx_ovf, rx_udf_unused;
  logic [DEST_W-1:0] rx_dest;
  logic              rx_match, rx_wr, rx_mis;
  logic [ERR_W-1:0]  err_q, err_d;

  sync_fifo_fwft #(.bits(bits), .depth(depth)) u_tx_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (tx_push),
    .wr_data_i   (tx_data),
    .rd_en_i     (pop),
    .rd_data_o   (D_pop),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count),
    .overflow_c  (tx_ovf),
    .underflow_c (tx_udf)
  );

  // Destination filter: only packets for this driver or broadcast enter RX.
  always_comb begin
    rx_dest  = dest_of(PKT_MAX_W'(D_push), bits);
    rx_match = (rx_dest == id) || (rx_dest == broadcast);
    rx_wr    = push && rx_match;
    rx_mis   = push && !rx_match;
  end

  sync_fifo_fwft #(.bits(bits), .depth(depth)) u_rx_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (rx_wr),
    .wr_data_i   (D_push),
    .rd_en_i     (rx_pop),
    .rd_data_o   (rx_data),
    .full_o      (rx_full_unused),
    .empty_o     (rx_empty),
    .count_o     (rx_count),
    .overflow_c  (rx_ovf),
    .underflow_c (rx_udf_unused)
  );

  // Sticky error flags; cleared only by reset.
  always_comb begin
    err_d                   = err_q;
    err_d[ERR_TX_OVERFLOW]  = err_q[ERR_TX_OVERFLOW]  | tx_ovf;
    err_d[ERR_TX_UNDERFLOW] = err_q[ERR_TX_UNDERFLOW] | tx_udf;
    err_d[ERR_RX_OVERFLOW]  = err_q[ERR_RX_OVERFLOW]  | rx_ovf;
    err_d[ERR_RX_MISROUTE]  = err_q[ERR_RX_MISROUTE]  | rx_mis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign pndng     = !tx_empty;
  assign rx_pndng  = !rx_empty;
  assign err_flags = err_q;

endmodule

// File: tb/tb_bus_drvr_fifo_if.sv
module tb_bus_drvr_fifo_if;

  localparam int unsigned BITS  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            tx_push, pop, push, rx_pop;
  logic [BITS-1:0] tx_data, D_push, D_pop, rx_data;
  logic            tx_full, pndng, rx_pndng;
  logic [CW-1:0]   tx_count, rx_count;
  logic [3:0]      err_flags;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_tx[$];
  logic [31:0] exp_rx[$];

  bus_drvr_fifo_if #(.bits(BITS), .depth(DEPTH), .id(8'h03), .broadcast(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_push   (tx_push),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .pndng     (pndng),
    .pop       (pop),
    .D_pop     (D_pop),
    .push      (push),
    .D_push    (D_push),
    .rx_pndng  (rx_pndng),
    .rx_pop    (rx_pop),
    .rx_data   (rx_data),
    .tx_count  (tx_count),
    .rx_count  (rx_count),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one clock; pulse inputs return to idle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    tx_push = 1'b0;
    pop     = 1'b0;
    push    = 1'b0;
    rx_pop  = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tx_count"},  32'(tx_count),  32'd0);
    chk({tag, "_rx_count"},  32'(rx_count),  32'd0);
    chk({tag, "_pndng"},     32'(pndng),     32'd0);
    chk({tag, "_rx_pndng"},  32'(rx_pndng),  32'd0);
    chk({tag, "_tx_full"},   32'(tx_full),   32'd0);
    chk({tag, "_err_flags"}, 32'(err_flags), 32'd0);
    chk({tag, "_D_pop"},     D_pop,          32'd0);
    chk({tag, "_rx_data"},   rx_data,        32'd0);
  endtask

  // Monitor: whenever a head is consumed, compare it with the scoreboard.
  always @(negedge clk) begin
    if (!reset && pop && pndng) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=%h required=none", D_pop);
      end else begin
        chk("tx_pop_data", D_pop, exp_tx.pop_front());
      end
    end
    if (!reset && rx_pop && rx_pndng) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%h required=none", rx_data);
      end else begin
        chk("rx_pop_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; tx_push = 1'b0; pop = 1'b0; push = 1'b0; rx_pop = 1'b0;
    tx_data = '0; D_push = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("reset");

    // First TX write falls through.
    tx_push = 1'b1; tx_data = 32'h0100_0001; exp_tx.push_back(32'h0100_0001); cyc();
    chk("tx_first_pndng", 32'(pndng), 32'd1);
    chk("tx_first_dpop", D_pop, 32'h0100_0001);
    chk("tx_first_count", 32'(tx_count), 32'd1);

    // Fill, overflow, then full write with coincident pop.
    for (int i = 2; i <= 4; i++) begin
      tx_push = 1'b1; tx_data = 32'h0100_0000 + 32'(i); exp_tx.push_back(tx_data); cyc();
    end
    chk("tx_fill_full", 32'(tx_full), 32'd1);
    chk("tx_fill_count", 32'(tx_count), 32'd4);
    chk("tx_fill_err", 32'(err_flags), 32'd0);
    tx_push = 1'b1; tx_data = 32'h0100_0005; cyc();
    chk("tx_ovf_count", 32'(tx_count), 32'd4);
    chk("tx_ovf_err", 32'(err_flags), 32'h1);
    chk("tx_ovf_head", D_pop, 32'h0100_0001);
    tx_push = 1'b1; tx_data = 32'h0100_0006; pop = 1'b1; exp_tx.push_back(32'h0100_0006); cyc();
    chk("tx_fullpop_count", 32'(tx_count), 32'd4);
    chk("tx_fullpop_full", 32'(tx_full), 32'd1);
    chk("tx_fullpop_head", D_pop, 32'h0100_0002);
    chk("tx_fullpop_err", 32'(err_flags), 32'h1);
    repeat (4) begin pop = 1'b1; cyc(); end
    chk("tx_drain_count", 32'(tx_count), 32'd0);
    chk("tx_drain_pndng", 32'(pndng), 32'd0);
    chk("tx_drain_dpop", D_pop, 32'd0);

    // Underflow, then push+pop on empty.
    pop = 1'b1; cyc();
    chk("tx_udf_err", 32'(err_flags), 32'h3);
    chk("tx_udf_count", 32'(tx_count), 32'd0);
    tx_push = 1'b1; tx_data = 32'h0100_0007; pop = 1'b1; exp_tx.push_back(32'h0100_0007); cyc();
    chk("tx_pushpop_count", 32'(tx_count), 32'd1);
    chk("tx_pushpop_pndng", 32'(pndng), 32'd1);
    chk("tx_pushpop_dpop", D_pop, 32'h0100_0007);
    chk("tx_pushpop_err", 32'(err_flags), 32'h3);
    pop = 1'b1; cyc();
    chk("tx_empty_again", 32'(tx_count), 32'd0);

    // RX filter: own ID, broadcast, misrouted.
    push = 1'b1; D_push = 32'h0300_00AA; exp_rx.push_back(32'h0300_00AA); cyc();
    push = 1'b1; D_push = 32'hFF00_00BB; exp_rx.push_back(32'hFF00_00BB); cyc();
    push = 1'b1; D_push = 32'h0500_00CC; cyc();
    chk("rx_filt_count", 32'(rx_count), 32'd2);
    chk("rx_filt_pndng", 32'(rx_pndng), 32'd1);
    chk("rx_filt_head", rx_data, 32'h0300_00AA);
    chk("rx_filt_err", 32'(err_flags), 32'hB);
    rx_pop = 1'b1; cyc();
    chk("rx_second_head", rx_data, 32'hFF00_00BB);
    rx_pop = 1'b1; cyc();
    chk("rx_drain_count", 32'(rx_count), 32'd0);
    chk("rx_drain_pndng", 32'(rx_pndng), 32'd0);
    chk("rx_drain_data", rx_data, 32'd0);
    rx_pop = 1'b1; cyc();
    chk("rx_pop_empty_err", 32'(err_flags), 32'hB);
    chk("rx_pop_empty_count", 32'(rx_count), 32'd0);

    // RX overflow, then full write with coincident rx_pop.
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; D_push = 32'h0300_0010 + 32'(i); exp_rx.push_back(D_push); cyc();
    end
    push = 1'b1; D_push = 32'h0300_0015; cyc();
    chk("rx_ovf_count", 32'(rx_count), 32'd4);
    chk("rx_ovf_err", 32'(err_flags), 32'hF);
    push = 1'b1; D_push = 32'h0300_0016; rx_pop = 1'b1; exp_rx.push_back(32'h0300_0016); cyc();
    chk("rx_fullpop_count", 32'(rx_count), 32'd4);
    chk("rx_fullpop_head", rx_data, 32'h0300_0012);
    repeat (4) begin rx_pop = 1'b1; cyc(); end
    chk("rx_drain2_count", 32'(rx_count), 32'd0);

    // Reset clears sticky flags; then pointer wrap-around through RX.
    reset = 1'b1; cyc();
    check_idle("reset2");
    for (int i = 1; i <= 10; i++) begin
      push = 1'b1; D_push = 32'h0300_0000 + 32'(i); rx_pop = (i > 1);
      exp_rx.push_back(D_push); cyc();
    end
    rx_pop = 1'b1; cyc();
    chk("wrap_count", 32'(rx_count), 32'd0);
    chk("wrap_pndng", 32'(rx_pndng), 32'd0);
    chk("wrap_err", 32'(err_flags), 32'd0);

    // Mid-traffic reset discards both FIFOs; coincident writes ignored.
    for (int i = 1; i <= 3; i++) begin
      tx_push = 1'b1; tx_data = 32'h0100_00A0 + 32'(i);
      push = 1'b1;
      D_push = (i <= 2) ? 32'h0300_00B0 + 32'(i) : 32'h0500_0000;
      cyc();
    end
    chk("pre_rst_tx_count", 32'(tx_count), 32'd3);
    chk("pre_rst_rx_count", 32'(rx_count), 32'd2);
    chk("pre_rst_err", 32'(err_flags), 32'h8);
    reset = 1'b1; tx_push = 1'b1; tx_data = 32'h0100_00FF; push = 1'b1; D_push = 32'h0300_00FF; cyc();
    check_idle("reset_mid");
    tx_push = 1'b1; tx_data = 32'h0100_00EE; exp_tx.push_back(32'h0100_00EE); cyc();
    chk("post_rst_count", 32'(tx_count), 32'd1);
    chk("post_rst_pndng", 32'(pndng), 32'd1);
    chk("post_rst_dpop", D_pop, 32'h0100_00EE);
    pop = 1'b1; cyc();
    chk("post_rst_drain", 32'(tx_count), 32'd0);

    chk("tx_scoreboard_empty", 32'(exp_tx.size()), 32'd0);
    chk("rx_scoreboard_empty", 32'(exp_rx.size()), 32'd0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_drvr_fifo_if.md
Name: bus_drvr_fifo_if

Overview:
Driver-side endpoint that sits directly on one driver slot of the 6-driver parallel bus generator/arbiter.
- TX path: buffers packets from the local agent (e.g. matrix-multiplier PE) and presents them to the arbiter via pndng/pop/D_pop.
- RX path: captures packets the bus delivers via push/D_push, filters them on destination ID, and queues them for the local agent.
- One instance per driver; six per bus.

Parameters:
bits, 32, packet width; destination ID occupies bits[bits-1:bits-8]
depth, 8, entries per FIFO (TX and RX each); power of 2, >=2
id, 0, this driver's 8-bit destination ID
broadcast, 8'hFF, destination ID accepted by every driver

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tx_push  in  1  local agent writes tx_data into TX FIFO
tx_data  in  bits  local packet to send
tx_full  out  1  TX FIFO holds depth entries
pndng  out  1  to arbiter: TX FIFO non-empty
pop  in  1  from arbiter: consume TX head this cycle
D_pop  out  bits  to arbiter: TX head packet (show-ahead)
push  in  1  from arbiter: packet delivered this cycle
D_push  in  bits  from arbiter: delivered packet
rx_pndng  out  1  RX FIFO non-empty
rx_pop  in  1  local agent consumes RX head
rx_data  out  bits  RX head packet (show-ahead)
tx_count  out  $clog2(depth)+1  TX occupancy
rx_count  out  $clog2(depth)+1  RX occupancy
err_flags  out  4  sticky: {rx_misroute, rx_overflow, tx_underflow, tx_overflow}

Behaviour:
- Reset: all outputs 0 (pndng, rx_pndng, tx_full, counts, err_flags, D_pop, rx_data). Pointers and counts are cleared; RAM contents are not cleared. A reset asserted mid-transfer discards all queued packets. A push/pop coincident with reset is ignored.
- Both FIFOs are first-word-fall-through:
  - A write at edge N into an empty FIFO makes pndng/rx_pndng=1 and the data valid after edge N (visible in cycle N+1).
  - D_pop/rx_data drive the head while non-empty and 0 when empty.
- Pop consumes the head at the clock edge. The next entry, or 0, appears the following cycle.
- TX write (tx_push):
  - Accepted if count<depth, or if count==depth and pop=1 in the same cycle (count unchanged).
  - If full with no pop, the packet is dropped and tx_overflow sets.
- TX read: pop while empty is ignored and sets tx_underflow. Simultaneous tx_push and pop on an empty FIFO: write only; the pop is treated as underflow.
- RX filter: on push, dest=D_push[bits-1:bits-8].
  - Accept if dest==id or dest==broadcast.
  - Otherwise drop and set rx_misroute.
- RX write:
  - Accepted if RX is not full, or if RX is full and rx_pop=1 in the same cycle.
  - Otherwise drop and set rx_overflow. The bus has no backpressure on push.
- rx_pop on empty RX is ignored; no flag.
- Counts: increment on accepted write, decrement on valid read, unchanged on both. tx_full = (tx_count==depth).
- Pointers are $clog2(depth) bits and wrap modulo depth. Occupancy is tracked separately, so full and empty are unambiguous.
- err_flags bits clear only on reset.

Decomposition:
- Shared package bus_if_pkg:
  - DEST_W=8
  - BROADCAST_ID=8'hFF
  - dest_of(pkt) slice function
  - err flag bit-index constants
- Sub-module sync_fifo_fwft, with parameters bits and depth and outputs full, empty, count, and overflow/underflow pulses. It is instantiated twice (TX, RX).
- The top level adds the RX ID filter, the sticky flag registers and the bus-name port mapping.

Test Plan:
- Reset then idle, depth=4: all outputs 0. Then tx_push 32'h0100_0001 at edge 1 → pndng=1 and D_pop=32'h0100_0001 in cycle 2, tx_count=1.
- Fill TX with 4 packets, then tx_push with pop=0 → tx_full=1, tx_count=4, err_flags[0]=1, D_pop still the first packet. Repeat with pop=1 the same cycle → accepted, count stays 4, no flag.
- With id=3: push D_push=32'h0300_00AA, then 32'hFF00_00BB, then 32'h0500_00CC → rx_count=2, rx_data=32'h0300_00AA then 32'hFF00_00BB, err_flags[3]=1.
- pop on empty TX → err_flags[1]=1, tx_count stays 0. Simultaneous tx_push + pop on empty → tx_count=1, pndng=1 next cycle.
- Wrap-around: 10 push/pop pairs of values 1..10 through depth=4 RX → rx_data order 1..10, no flags.
- Assert reset with TX=3 and RX=2 entries → next cycle all counts, pndng, rx_pndng and err_flags are 0; a subsequent tx_push works normally.
